// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes double as big-mux input indices.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SEL_W_DEF = 3;
  localparam int ITER_W    = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Single-issue ALU controller: latches operands, waits ALU_LAT per iteration,
// iterates the single-bit shifters, then holds the result until accepted.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [SEL_W-1:0] cmdOp,
  input  logic [WIDTH-1:0] cmdA,
  input  logic [WIDTH-1:0] cmdB,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [SEL_W-1:0] bigMuxSel,
  input  logic [WIDTH-1:0] aluResult,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] resData,
  output logic             resZero,
  output logic             busy
);

  localparam int               LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

  state_e              state_q;
  logic [WIDTH-1:0]    aluA_q, aluB_q, resData_q;
  logic [SEL_W-1:0]    sel_q;
  logic                resValid_q;
  logic [LAT_W-1:0]    latCnt_q;
  logic [ITER_W-1:0]   iter_q;
  logic                isShift;

  assign isShift = (cmdOp == SEL_W'(OP_SHL)) || (cmdOp == SEL_W'(OP_SHR));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_IDLE;
      aluA_q     <= '0;
      aluB_q     <= '0;
      sel_q      <= '0;
      resData_q  <= '0;
      resValid_q <= 1'b0;
      latCnt_q   <= '0;
      iter_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmdValid) begin
          aluA_q   <= cmdA;
          sel_q    <= cmdOp;
          latCnt_q <= '0;
          if (isShift) begin
            // shifters are single-bit units driven from A only; B[3:0] is the count
            aluB_q <= '0;
            iter_q <= cmdB[ITER_W-1:0];
            if (cmdB[ITER_W-1:0] == '0) begin
              resData_q  <= cmdA;
              resValid_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              state_q <= ST_EXEC;
            end
          end else begin
            aluB_q  <= cmdB;
            iter_q  <= ITER_W'(1);
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (latCnt_q == LAT_LAST) begin
            latCnt_q <= '0;
            if (iter_q > ITER_W'(1)) begin
              aluA_q <= aluResult;
              iter_q <= iter_q - ITER_W'(1);
            end else begin
              resData_q  <= aluResult;
              resValid_q <= 1'b1;
              state_q    <= ST_DONE;
            end
          end else begin
            latCnt_q <= latCnt_q + LAT_W'(1);
          end
        end
        ST_DONE: if (resReady) begin
          resValid_q <= 1'b0;
          sel_q      <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmdReady  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign aluA      = aluA_q;
  assign aluB      = aluB_q;
  assign bigMuxSel = sel_q;
  assign resValid  = resValid_q;
  assign resData   = resData_q;
  assign resZero   = (resData_q == '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: two instances (ALU_LAT=1 and 3), each
// fed by a behavioural big-mux ALU.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  cmdOp;
  logic [15:0] cmdA, cmdB;

  logic        cmdValid1, cmdReady1, resValid1, resReady1, resZero1, busy1;
  logic [15:0] aluA1, aluB1, aluRes1, resData1;
  logic [2:0]  sel1;

  logic        cmdValid3, cmdReady3, resValid3, resReady3, resZero3, busy3;
  logic [15:0] aluA3, aluB3, aluRes3, resData3;
  logic [2:0]  sel3;

  int vecs = 0;
  int errs = 0;
  int cyc;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a | b;
      3'd3: alu = a & b;
      3'd4: alu = a ^ b;
      3'd5: alu = ~a;
      3'd6: alu = a << 1;
      default: alu = a >> 1;
    endcase
  endfunction

  always_comb aluRes1 = alu(sel1, aluA1, aluB1);
  always_comb aluRes3 = alu(sel3, aluA3, aluB3);

  alu_op_sequencer #(.WIDTH(16), .SEL_W(3), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rstN(rstN), .cmdValid(cmdValid1), .cmdReady(cmdReady1),
    .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB), .aluA(aluA1), .aluB(aluB1),
    .bigMuxSel(sel1), .aluResult(aluRes1), .resValid(resValid1),
    .resReady(resReady1), .resData(resData1), .resZero(resZero1), .busy(busy1)
  );

  alu_op_sequencer #(.WIDTH(16), .SEL_W(3), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rstN(rstN), .cmdValid(cmdValid3), .cmdReady(cmdReady3),
    .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB), .aluA(aluA3), .aluB(aluB3),
    .bigMuxSel(sel3), .aluResult(aluRes3), .resValid(resValid3),
    .resReady(resReady3), .resData(resData3), .resZero(resZero3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of cycle 1 after the accept edge.
  task automatic start1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    cmdOp = op; cmdA = a; cmdB = b; cmdValid1 = 1'b1;
    @(negedge clk);
    cmdValid1 = 1'b0;
  endtask

  task automatic wait_res1(output int c);
    c = 1;
    while (!resValid1 && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic accept1();
    resReady1 = 1'b1;
    @(negedge clk);
    resReady1 = 1'b0;
    chk("idle_ready", cmdReady1, 1'b1);
    chk("idle_sel", sel1, 3'd0);
  endtask

  initial begin
    logic [15:0] shlSteps [4];
    shlSteps = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
    rstN = 1'b0; cmdOp = '0; cmdA = '0; cmdB = '0;
    cmdValid1 = 1'b0; resReady1 = 1'b0; cmdValid3 = 1'b0; resReady3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmdReady1, 1'b1);
    chk("rst_valid", resValid1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_aluA", aluA1, 16'h0);
    chk("rst_sel", sel1, 3'd0);
    chk("rst_data", resData1, 16'h0);
    chk("rst_valid3", resValid3, 1'b0);
    rstN = 1'b1;

    // AND
    start1(3'd3, 16'hF0F0, 16'hFF00);
    chk("and_sel", sel1, 3'd3);
    chk("and_busy", busy1, 1'b1);
    wait_res1(cyc);
    chk("and_lat", cyc, 2);
    chk("and_data", resData1, 16'hF000);
    chk("and_zero", resZero1, 1'b0);
    accept1();

    // SHL by 4
    start1(3'd6, 16'h0001, 16'h0004);
    for (int i = 0; i < 4; i++) begin
      chk("shl_aluA", aluA1, shlSteps[i]);
      chk("shl_pending", resValid1, 1'b0);
      @(negedge clk);
    end
    chk("shl_valid_c5", resValid1, 1'b1);
    chk("shl_data", resData1, 16'h0010);
    accept1();

    // SHR by 0: done in cycle 1
    start1(3'd7, 16'h8001, 16'h0000);
    chk("shr0_valid_c1", resValid1, 1'b1);
    chk("shr0_data", resData1, 16'h8001);
    accept1();

    // SUB to zero
    start1(3'd1, 16'h1234, 16'h1234);
    wait_res1(cyc);
    chk("sub_lat", cyc, 2);
    chk("sub_data", resData1, 16'h0000);
    chk("sub_zero", resZero1, 1'b1);
    accept1();

    // Backpressure with junk commands offered during the stall
    start1(3'd0, 16'h1111, 16'h2222);
    wait_res1(cyc);
    chk("bp_lat", cyc, 2);
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", resValid1, 1'b1);
      chk("bp_data", resData1, 16'h3333);
      chk("bp_sel", sel1, 3'd0);
      chk("bp_ready", cmdReady1, 1'b0);
      chk("bp_busy", busy1, 1'b1);
      cmdOp = 3'd2; cmdA = 16'hA5A5 + 16'(i); cmdB = 16'h5A5A; cmdValid1 = 1'b1;
      @(negedge clk);
    end
    chk("bp_data_end", resData1, 16'h3333);
    cmdOp = 3'd4; cmdA = 16'h00FF; cmdB = 16'h0F0F; resReady1 = 1'b1;
    @(negedge clk);
    resReady1 = 1'b0;
    chk("bp_idle_ready", cmdReady1, 1'b1);
    chk("bp_idle_busy", busy1, 1'b0);
    chk("bp_idle_valid", resValid1, 1'b0);
    @(negedge clk);
    cmdValid1 = 1'b0;
    chk("bp_xor_sel", sel1, 3'd4);
    chk("bp_xor_aluA", aluA1, 16'h00FF);
    wait_res1(cyc);
    chk("bp_xor_lat", cyc, 2);
    chk("bp_xor_data", resData1, 16'h0FF0);
    accept1();

    // Reset in the 3rd EXEC cycle of a shift
    start1(3'd6, 16'h0003, 16'h0008);
    repeat (2) @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    chk("mrst_ready", cmdReady1, 1'b1);
    chk("mrst_valid", resValid1, 1'b0);
    chk("mrst_aluA", aluA1, 16'h0);
    chk("mrst_busy", busy1, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    start1(3'd3, 16'hFFFF, 16'hFFFF);
    wait_res1(cyc);
    chk("mrst_and_lat", cyc, 2);
    chk("mrst_and_data", resData1, 16'hFFFF);
    accept1();

    // ALU_LAT=3 SHL by 2
    @(negedge clk);
    cmdOp = 3'd6; cmdA = 16'h0001; cmdB = 16'h0002; cmdValid3 = 1'b1;
    @(negedge clk);
    cmdValid3 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("lat3_aluA", aluA3, (c <= 3) ? 16'h0001 : 16'h0002);
      chk("lat3_pending", resValid3, 1'b0);
      @(negedge clk);
    end
    chk("lat3_valid_c7", resValid3, 1'b1);
    chk("lat3_data", resData3, 16'h0004);
    resReady3 = 1'b1;
    @(negedge clk);
    resReady3 = 1'b0;
    chk("lat3_idle", cmdReady3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
